// File: rtl/sync_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Backs the cache data and tag arrays; the read path is write-first on collision.
module sync_ram #(
  parameter int    WIDTH      = 32,
  parameter int    ADDR_WIDTH = 8,
  parameter string TAG        = "ram"
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [WIDTH-1:0]      dataIn,
  output logic [WIDTH-1:0]      dataOut
);

  localparam int Depth = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [Depth];
  logic             collide;

  assign collide = we && (readAddr == writeAddr);

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (res && we) begin
      mem[writeAddr] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      dataOut <= '0;
    end else if (re) begin
      dataOut <= collide ? dataIn : mem[readAddr];
    end
  end

`ifdef DEBUG_DISPLAY
  always_ff @(posedge clk) begin
    if (res && we) begin
      $display("[%s] write 0x%h to 0x%h", TAG, dataIn, writeAddr);
    end
  end
`endif

endmodule

// File: tb/tb_sync_ram.sv
// Directed bench for sync_ram: reset, latency, hold,
// collision, port independence and a full sweep.
module tb_sync_ram;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  readAddr = '0;
  logic [3:0]  writeAddr = '0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;

  int total = 0;
  int bad = 0;

  sync_ram #(
    .WIDTH(32),
    .ADDR_WIDTH(4),
    .TAG("tbram")
  ) dut (
    .clk(clk),
    .res(res),
    .re(re),
    .we(we),
    .readAddr(readAddr),
    .writeAddr(writeAddr),
    .dataIn(dataIn),
    .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // async reset mid-cycle
    @(negedge clk);
    #2 res = 1'b0;
    #1 chk("rst_async", dataOut, 32'h0);
    step();
    res = 1'b1;
    step();
    step();
    chk("rst_hold", dataOut, 32'h0);

    // write then read, one cycle latency
    we = 1'b1; writeAddr = 4'd3; dataIn = 32'hDEADBEEF;
    step();
    we = 1'b0; re = 1'b1; readAddr = 4'd3;
    step();
    chk("rd3", dataOut, 32'hDEADBEEF);

    // hold while the address is rewritten
    re = 1'b0; we = 1'b1; writeAddr = 4'd3; dataIn = 32'h12345678;
    step();
    chk("hold", dataOut, 32'hDEADBEEF);
    we = 1'b0;
    step();
    chk("hold2", dataOut, 32'hDEADBEEF);
    re = 1'b1; readAddr = 4'd3;
    step();
    chk("rd3new", dataOut, 32'h12345678);

    // same-address collision: write-first
    re = 1'b1; we = 1'b1; readAddr = 4'd5; writeAddr = 4'd5;
    dataIn = 32'hA5A5A5A5;
    step();
    chk("coll", dataOut, 32'hA5A5A5A5);
    we = 1'b0; dataIn = 32'h0;
    step();
    chk("coll_mem", dataOut, 32'hA5A5A5A5);

    // different addresses on one edge read old data
    re = 1'b0; we = 1'b1; writeAddr = 4'd15; dataIn = 32'h2;
    step();
    re = 1'b1; readAddr = 4'd15; writeAddr = 4'd0; dataIn = 32'h1;
    step();
    chk("indep15", dataOut, 32'h2);
    we = 1'b0; readAddr = 4'd0;
    step();
    chk("indep0", dataOut, 32'h1);

    // read of a different address while writing it the same edge
    we = 1'b1; writeAddr = 4'd15; dataIn = 32'h77; readAddr = 4'd0;
    step();
    chk("indep_old", dataOut, 32'h1);

    // sweep
    re = 1'b0; we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      writeAddr = 4'(i); dataIn = 32'(i);
      step();
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      readAddr = 4'(i);
      step();
      chk($sformatf("sweep%0d", i), dataOut, 32'(i));
    end

    // reset mid-stream, contents survive, first edge after release reads
    readAddr = 4'd7;
    #2 res = 1'b0;
    #1 chk("rst_mid", dataOut, 32'h0);
    @(negedge clk);
    res = 1'b1;
    step();
    chk("rst_rel_rd", dataOut, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
